// File: rtl/hex_word_streamer_if.sv
// hex_word_streamer_if: word-in / ASCII-char-out handshake bundle for hex_word_streamer
//   word_data/word_valid/word_ready : parallel word input handshake
//   eol_flush                       : pulse requesting CR LF on the current partial line
//   char_data/char_valid/char_ready : ASCII byte output handshake towards UART TX
//   busy                            : streamer is not idle
//   slave modport is the streamer side, master modport is the producer/consumer side
interface hex_word_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;
    logic                  eol_flush;
    logic [7:0]            char_data;
    logic                  char_valid;
    logic                  char_ready;
    logic                  busy;
    modport slave (
        input  word_data, word_valid, eol_flush, char_ready,
        output word_ready, char_data, char_valid, busy
    );
    modport master (
        output word_data, word_valid, eol_flush, char_ready,
        input  word_ready, char_data, char_valid, busy
    );
endinterface

// File: rtl/hex_word_streamer.sv
// hex_word_streamer: serialises words into uppercase ASCII hex with separators and CR LF line breaks
//   binascii ports: i_nib (4-bit value), o_char (ASCII '0'-'9','A'-'F')
//   hex_word_streamer ports: clk, rst (async active-high), bus (hex_word_streamer_if.slave,
//   DATA_WIDTH of the interface must match the module parameter)
module binascii (
    input  logic [3:0] i_nib,
    output logic [7:0] o_char
);
    always_comb o_char = (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib}) : (8'h37 + {4'h0, i_nib});
endmodule

module hex_word_streamer #(
    parameter int         DATA_WIDTH     = 32,
    parameter int         WORDS_PER_LINE = 8,
    parameter logic [7:0] SEP_CHAR       = 8'h20
) (
    input logic                 clk,
    input logic                 rst,
    hex_word_streamer_if.slave  bus
);
    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int IW      = $clog2(NIBBLES) + 1;
    localparam int CW      = $clog2(WORDS_PER_LINE) + 1;

    typedef enum logic [2:0] {IDLE, HEX, SEP, CR, LF} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_count;
    logic                  r_flush;
    logic [7:0]            r_char;
    logic                  r_valid;
    logic                  r_ready;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_shift_nx;
    logic [3:0]            w_nib;
    logic [7:0]            w_ascii;

    // r_shift keeps the nibble on display at its top; the converter always looks one
    // nibble ahead so the next char can be registered on the current handshake.
    assign w_shift_nx = r_shift << 4;
    assign w_nib      = (r_state == IDLE) ? bus.word_data[DATA_WIDTH-1 -: 4] : w_shift_nx[DATA_WIDTH-1 -: 4];

    binascii u_binascii (
        .i_nib  (w_nib),
        .o_char (w_ascii)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_flush <= r_flush | bus.eol_flush;
            unique case (r_state)
                IDLE: begin
                    // a word offered together with a pending flush goes first
                    if (bus.word_valid && r_ready) begin
                        r_shift <= bus.word_data;
                        r_idx   <= IW'(NIBBLES - 1);
                        r_char  <= w_ascii;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= HEX;
                    end else if (r_flush && r_count != '0) begin
                        r_char  <= 8'h0D;
                        r_valid <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CR;
                    end else begin
                        r_ready <= 1'b1;
                        if (r_flush) r_flush <= 1'b0;
                    end
                end
                HEX: begin
                    if (bus.char_ready) begin
                        if (r_idx != '0) begin
                            r_idx   <= r_idx - IW'(1);
                            r_shift <= w_shift_nx;
                            r_char  <= w_ascii;
                        end else if (r_count == CW'(WORDS_PER_LINE - 1)) begin
                            r_char  <= 8'h0D;
                            r_state <= CR;
                        end else begin
                            r_char  <= SEP_CHAR;
                            r_count <= r_count + CW'(1);
                            r_state <= SEP;
                        end
                    end
                end
                SEP: begin
                    if (bus.char_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                CR: begin
                    if (bus.char_ready) begin
                        r_char  <= 8'h0A;
                        r_state <= LF;
                    end
                end
                LF: begin
                    // the line break also absorbs any flush that arrived meanwhile
                    if (bus.char_ready) begin
                        r_count <= '0;
                        r_flush <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.word_ready = r_ready;
    assign bus.char_data  = r_char;
    assign bus.char_valid = r_valid;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_hex_word_streamer.sv
// tb_hex_word_streamer: directed scoreboard bench for hex_word_streamer (32-bit/8-per-line and 8-bit/1-per-line)
module tb_hex_word_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;
    bit   stab_en = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    hex_word_streamer_if #(.DATA_WIDTH(32)) a_if();
    hex_word_streamer_if #(.DATA_WIDTH(8))  b_if();

    hex_word_streamer #(.DATA_WIDTH(32), .WORDS_PER_LINE(8), .SEP_CHAR(8'h20)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    hex_word_streamer #(.DATA_WIDTH(8), .WORDS_PER_LINE(1), .SEP_CHAR(8'h20)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'd48 + 8'(n) : 8'd65 + 8'(n) - 8'd10;
    endfunction

    // Output scoreboards: every accepted char must be the next expected one
    logic [7:0] held;
    bit         stalled = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (a_if.char_valid && a_if.char_ready) begin
            e = (qa.size() != 0) ? {1'b1, qa.pop_front()} : 9'h000;
            check("char_a", {23'h0, 1'b1, a_if.char_data}, {23'h0, e});
        end
        if (stab_en) begin
            if (stalled) check("stall_hold", {23'h0, a_if.char_valid, a_if.char_data}, {23'h0, 1'b1, held});
            stalled = a_if.char_valid && !a_if.char_ready;
            held    = a_if.char_data;
        end else stalled = 1'b0;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (b_if.char_valid && b_if.char_ready) begin
            e = (qb.size() != 0) ? {1'b1, qb.pop_front()} : 9'h000;
            check("char_b", {23'h0, 1'b1, b_if.char_data}, {23'h0, e});
        end
    end

    task automatic send_word(input logic [31:0] d, input bit fl);
        bit ok = 1'b0;
        for (int i = 7; i >= 0; i--) qa.push_back(hexc(d[i*4 +: 4]));
        if (mcount == 7) begin
            qa.push_back(8'h0D); qa.push_back(8'h0A); mcount = 0;
        end else begin
            qa.push_back(8'h20); mcount++;
        end
        if (fl && mcount != 0) begin
            qa.push_back(8'h0D); qa.push_back(8'h0A); mcount = 0;
        end
        a_if.word_data  = d;
        a_if.word_valid = 1'b1;
        a_if.eol_flush  = fl;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = a_if.word_ready;
        end
        @(posedge clk); #1;
        a_if.word_valid = 1'b0;
        a_if.eol_flush  = 1'b0;
        check("accept_a", {31'h0, ok}, 32'h1);
    endtask

    task automatic flush_a();
        if (mcount != 0) begin
            qa.push_back(8'h0D); qa.push_back(8'h0A); mcount = 0;
        end
        a_if.eol_flush = 1'b1;
        @(posedge clk); #1;
        a_if.eol_flush = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (qa.size() == 0 && !a_if.busy) break;
        end
        check(tag, {a_if.busy, 31'(qa.size())}, 32'h0);
    endtask

    task automatic send_b(input logic [7:0] d);
        bit ok = 1'b0;
        qb.push_back(hexc(d[7:4])); qb.push_back(hexc(d[3:0]));
        qb.push_back(8'h0D); qb.push_back(8'h0A);
        b_if.word_data  = d;
        b_if.word_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = b_if.word_ready;
        end
        @(posedge clk); #1;
        b_if.word_valid = 1'b0;
        check("accept_b", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        int n;
        int st;
        a_if.word_data = '0; a_if.word_valid = 1'b0; a_if.eol_flush = 1'b0; a_if.char_ready = 1'b1;
        b_if.word_data = '0; b_if.word_valid = 1'b0; b_if.eol_flush = 1'b0; b_if.char_ready = 1'b1;
        // reset state
        @(negedge clk);
        check("rst_outs_a", {a_if.word_ready, a_if.char_valid, a_if.busy, a_if.char_data}, 32'h0);
        check("rst_outs_b", {b_if.word_ready, b_if.char_valid, b_if.busy}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_pre", {31'h0, a_if.word_ready}, 32'h0);
        @(negedge clk);
        check("ready_post", {31'h0, a_if.word_ready}, 32'h1);
        // single word, latency and throughput
        @(posedge clk); #1;
        send_word(32'hDEADBEEF, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("first_valid", {31'h0, a_if.char_valid}, 32'h1);
        end while (!a_if.word_ready && n < 40);
        check("ready_latency", n, 10);
        wait_idle_a("idle_t1");
        flush_a();
        wait_idle_a("idle_flush1");
        // one full line
        for (int i = 0; i < 8; i++) send_word(32'h0123456F, 1'b0);
        wait_idle_a("idle_line");
        // count is back to zero, so an idle flush prints nothing
        flush_a();
        repeat (10) @(posedge clk);
        #1 check("idle_flush_quiet", {a_if.char_valid, a_if.busy}, 32'h0);
        // random backpressure
        send_word(32'hA5A50F0F, 1'b0);
        stab_en = 1'b1;
        st = 0;
        for (int i = 0; i < 400 && qa.size() != 0; i++) begin
            @(posedge clk); #1;
            if (st > 0) begin
                a_if.char_ready = 1'b0; st--;
            end else begin
                a_if.char_ready = 1'b1; st = $urandom_range(0, 5);
            end
        end
        a_if.char_ready = 1'b1;
        stab_en = 1'b0;
        wait_idle_a("idle_stall");
        // partial line flush, flush with word, flush absorbed by line end
        for (int i = 0; i < 2; i++) send_word(32'h00000000 + i, 1'b0);
        flush_a();
        wait_idle_a("idle_partial_flush");
        send_word(32'hCAFEF00D, 1'b1);
        wait_idle_a("idle_word_flush");
        for (int i = 0; i < 7; i++) send_word(32'h1111_0000 + i, 1'b0);
        send_word(32'h89ABCDEF, 1'b1);
        wait_idle_a("idle_absorb");
        repeat (20) @(posedge clk);
        #1 check("absorb_quiet", {a_if.char_valid, a_if.busy}, 32'h0);
        // reset during the 4th nibble
        send_word(32'hDEADBEEF, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("nib4", {23'h0, a_if.char_valid, a_if.char_data}, {23'h0, 1'b1, 8'h44});
        rst = 1'b1;
        #1 check("mid_rst_outs", {a_if.word_ready, a_if.char_valid, a_if.busy}, 32'h0);
        qa.delete();
        mcount = 0;
        @(negedge clk);
        check("mid_rst_hold", {31'h0, a_if.char_valid}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        send_word(32'h13579BDF, 1'b0);
        wait_idle_a("idle_after_rst");
        // 8-bit words, one word per line
        send_b(8'h7C);
        send_b(8'hA0);
        for (int i = 0; i < 100 && (qb.size() != 0 || b_if.busy); i++) @(posedge clk);
        #1 check("idle_b", {b_if.busy, 31'(qb.size())}, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
